// File: rtl/tia_phase_gen_pkg.sv
// Shared definitions for the TIA two-phase strobe generator: state encodings,
// default phase/gap lengths and the counter width helper.
package tia_phase_gen_pkg;

    localparam int TIA_DEF_PH_LEN  = 2;
    localparam int TIA_DEF_GAP_LEN = 1;

    typedef enum logic [2:0] {
        TIA_PH_IDLE = 3'd0,
        TIA_PH_PH1  = 3'd1,
        TIA_PH_GAP1 = 3'd2,
        TIA_PH_PH2  = 3'd3,
        TIA_PH_GAP2 = 3'd4
    } tia_ph_state_e;

    // Bits needed to hold max(ph_len, gap_len), never less than one.
    function automatic int cnt_width(int ph_len, int gap_len);
        int m;
        int w;
        m = (ph_len > gap_len) ? ph_len : gap_len;
        w = $clog2(m + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/tia_phase_gen_if.sv
// Strobe bundle between a tia_phase_gen instance and its controller / latch chain.
// The rsync restart request exists only when TIA_PHASE_RESYNC_EN is defined.
interface tia_phase_gen_if;

    logic enable;
    logic s1;
    logic s2;
    logic s1_rise;
    logic busy;
`ifdef TIA_PHASE_RESYNC_EN
    logic rsync;

    modport master (output enable, output rsync, input s1, input s2, input s1_rise, input busy);
    modport slave  (input enable, input rsync, output s1, output s2, output s1_rise, output busy);
`else
    modport master (output enable, input s1, input s2, input s1_rise, input busy);
    modport slave  (input enable, output s1, output s2, output s1_rise, output busy);
`endif

endinterface

// File: rtl/tia_phase_timer.sv
// Loadable down-counter that sits at zero; done marks the last cycle of a phase.
module tia_phase_timer #(
    parameter int CW = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          done
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Load takes priority; otherwise count down and hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/tia_phase_gen.sv
// Non-overlapping two-phase strobe generator (s1 -> gap -> s2 -> gap) for tia_d1
// latch chains. Define TIA_PHASE_RESYNC_EN to add the rsync restart request.
module tia_phase_gen
    import tia_phase_gen_pkg::*;
#(
    parameter int PH_LEN  = TIA_DEF_PH_LEN,
    parameter int GAP_LEN = TIA_DEF_GAP_LEN
) (
    input  logic            clk,
    input  logic            reset,
    tia_phase_gen_if.slave  io
);

    localparam int            CW       = cnt_width(PH_LEN, GAP_LEN);
    localparam logic [CW-1:0] PH_LOAD  = CW'(PH_LEN - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_LEN - 1);

    if (PH_LEN < 1 || GAP_LEN < 1) begin : g_param_check
        $error("tia_phase_gen: PH_LEN and GAP_LEN must both be >= 1");
    end

    tia_ph_state_e state_q, state_d;
    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          s1_rise_q, s1_rise_d;
    logic          busy_q, busy_d;
    logic          load;
    logic [CW-1:0] load_val;
    logic          done;
    logic          rsync_hit;

    tia_phase_timer #(.CW(CW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .done     (done)
    );

    // Next state, timer load on every state entry, and next registered outputs.
    always_comb begin
        state_d   = state_q;
        rsync_hit = 1'b0;
        case (state_q)
            TIA_PH_IDLE: if (io.enable) state_d = TIA_PH_PH1;
            TIA_PH_PH1:  if (done)      state_d = TIA_PH_GAP1;
            TIA_PH_GAP1: if (done)      state_d = TIA_PH_PH2;
            TIA_PH_PH2:  if (done)      state_d = TIA_PH_GAP2;
            TIA_PH_GAP2: if (done)      state_d = io.enable ? TIA_PH_PH1 : TIA_PH_IDLE;
            default:                    state_d = TIA_PH_IDLE;
        endcase
`ifdef TIA_PHASE_RESYNC_EN
        // A restart parks in GAP2 with a fresh count so the gap rule still holds.
        if (io.rsync && state_q != TIA_PH_IDLE) begin
            state_d   = TIA_PH_GAP2;
            rsync_hit = 1'b1;
        end
`endif
        load = (state_d != state_q) || rsync_hit;
        case (state_d)
            TIA_PH_PH1, TIA_PH_PH2:   load_val = PH_LOAD;
            TIA_PH_GAP1, TIA_PH_GAP2: load_val = GAP_LOAD;
            default:                  load_val = '0;
        endcase
        s1_d      = (state_d == TIA_PH_PH1);
        s2_d      = (state_d == TIA_PH_PH2);
        s1_rise_d = (state_d == TIA_PH_PH1) && (state_q != TIA_PH_PH1);
        busy_d    = (state_d != TIA_PH_IDLE);
    end

    // State and strobe registers; reset drops everything with no gap enforced.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= TIA_PH_IDLE;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s1_rise_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            s1_rise_q <= s1_rise_d;
            busy_q    <= busy_d;
        end
    end

    assign io.s1      = s1_q;
    assign io.s2      = s2_q;
    assign io.s1_rise = s1_rise_q;
    assign io.busy    = busy_q;

endmodule

// File: tb/tb_tia_phase_gen.sv
// Scoreboard bench for tia_phase_gen: a default instance and a PH_LEN=1/GAP_LEN=3
// instance share stimulus; a position-in-period model predicts each cycle's outputs.
module tb_tia_phase_gen;

    localparam int PH_A  = 2;
    localparam int GAP_A = 1;
    localparam int PH_B  = 1;
    localparam int GAP_B = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    tia_phase_gen_if bus_a ();
    tia_phase_gen_if bus_b ();

    tia_phase_gen #(.PH_LEN(PH_A), .GAP_LEN(GAP_A)) dut_a (.clk(clk), .reset(reset), .io(bus_a));
    tia_phase_gen #(.PH_LEN(PH_B), .GAP_LEN(GAP_B)) dut_b (.clk(clk), .reset(reset), .io(bus_b));

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_a[$];
    logic [3:0] exp_b[$];
    int pos_a = -1;
    int pos_b = -1;
    bit done_flag = 1'b0;

    // Position within the 2*(ph+gap) period, -1 meaning idle.
    function automatic int next_pos(int pos, int ph, int gap, bit en, bit rst, bit rs);
        int period;
        period = 2 * (ph + gap);
        if (rst) return -1;
        if (rs && pos >= 0) return 2 * ph + gap;
        if (pos < 0 || pos == period - 1) return en ? 0 : -1;
        return pos + 1;
    endfunction

    // {s1, s2, s1_rise, busy} seen while at a given position.
    function automatic logic [3:0] outputs_at(int pos, int ph, int gap);
        logic s1, s2, r, b;
        b  = (pos >= 0);
        s1 = b && (pos < ph);
        s2 = (pos >= ph + gap) && (pos < 2 * ph + gap);
        r  = (pos == 0);
        return {s1, s2, r, b};
    endfunction

    task automatic step(bit en, bit rst, bit rs);
        bit rs_eff;
        @(negedge clk);
        reset = rst;
        bus_a.enable = en;
        bus_b.enable = en;
`ifdef TIA_PHASE_RESYNC_EN
        bus_a.rsync = rs;
        bus_b.rsync = rs;
        rs_eff = rs;
`else
        rs_eff = 1'b0;
`endif
        pos_a = next_pos(pos_a, PH_A, GAP_A, en, rst, rs_eff);
        pos_b = next_pos(pos_b, PH_B, GAP_B, en, rst, rs_eff);
        exp_a.push_back(outputs_at(pos_a, PH_A, GAP_A));
        exp_b.push_back(outputs_at(pos_b, PH_B, GAP_B));
    endtask

    // Monitor: one output word per cycle per instance, plus the no-overlap rule.
    initial begin
        logic [3:0] got, want;
        forever begin
            @(posedge clk);
            #1;
            if (done_flag) break;
            if (exp_a.size() > 0) begin
                want = exp_a.pop_front();
                got  = {bus_a.s1, bus_a.s2, bus_a.s1_rise, bus_a.busy};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL outputs_a t=%0t got {s1,s2,rise,busy}=%b want %b", $time, got, want);
                end
                checks++;
                if ((bus_a.s1 & bus_a.s2) !== 1'b0) begin
                    errors++;
                    $display("FAIL overlap_a t=%0t got s1&s2=%b want 0", $time, bus_a.s1 & bus_a.s2);
                end
            end
            if (exp_b.size() > 0) begin
                want = exp_b.pop_front();
                got  = {bus_b.s1, bus_b.s2, bus_b.s1_rise, bus_b.busy};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL outputs_b t=%0t got {s1,s2,rise,busy}=%b want %b", $time, got, want);
                end
                checks++;
                if ((bus_b.s1 & bus_b.s2) !== 1'b0) begin
                    errors++;
                    $display("FAIL overlap_b t=%0t got s1&s2=%b want 0", $time, bus_b.s1 & bus_b.s2);
                end
            end
        end
    end

    initial begin
        bus_a.enable = 1'b0;
        bus_b.enable = 1'b0;
`ifdef TIA_PHASE_RESYNC_EN
        bus_a.rsync = 1'b0;
        bus_b.rsync = 1'b0;
`endif
        repeat (3) step(0, 1, 0);
        // Free-running with enable held high.
        repeat (24) step(1, 0, 0);
        repeat (2) step(0, 1, 0);
        // Enable dropped during the first PH1 cycle: sequence completes, then idle.
        step(1, 0, 0);
        repeat (12) step(0, 0, 0);
        // Reset landing in the second PH2 cycle of the default instance.
        repeat (5) step(1, 0, 0);
        step(1, 1, 0);
        repeat (3) step(0, 0, 0);
`ifdef TIA_PHASE_RESYNC_EN
        // rsync while idle is ignored.
        repeat (5) step(0, 0, 1);
        // rsync in the first PH1 cycle restarts through a full gap.
        step(1, 0, 0);
        step(1, 0, 1);
        repeat (10) step(1, 0, 0);
        // rsync held high keeps the block parked in GAP2.
        repeat (4) step(1, 0, 1);
        repeat (8) step(1, 0, 0);
`endif
        // Randomized run.
        repeat (1200) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 99) == 0, $urandom_range(0, 15) == 0);
        end
        repeat (2) step(0, 0, 0);
        @(posedge clk);
        #2;
        checks++;
        if (exp_a.size() != 0 || exp_b.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d/%0d pending want 0/0", exp_a.size(), exp_b.size());
        end
        done_flag = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
